// File: rtl/game_round_ctrl.sv
// game_round_ctrl: sequences a guess-the-number game of ROUNDS rounds.
// Each round requests a target, gives the player TIME_LIMIT ticks to
// press start with a guess on sw, scores a hit on an exact match, then
// beeps (hits only) for BEEP_TICKS ticks before the next round.
// Every output is driven straight from a flop.
module game_round_ctrl #(
   parameter int ROUNDS     = 3,
   parameter int TIME_LIMIT = 9,
   parameter int BEEP_TICKS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic [6:0] sw,
   input  logic [6:0] target,
   output logic       target_req,
   output logic [2:0] state,
   output logic [3:0] round,
   output logic [3:0] score,
   output logic [3:0] time_left,
   output logic       hit,
   output logic       beep_en,
   output logic       game_over
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_PLAY   = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;
   localparam logic [2:0] S_OVER   = 3'd5;

   localparam logic [3:0] TIME_INIT = 4'(TIME_LIMIT);
   localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);
   localparam logic [3:0] BEEP_L    = 4'(BEEP_TICKS);

   logic [2:0] state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [3:0] score_q, score_d;
   logic [3:0] time_q, time_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] guess_q, guess_d;
   logic       start_d_q, start_d_d;
   logic       armed_q, armed_d;
   logic       target_req_q, target_req_d;
   logic       hit_q, hit_d;
   logic       beep_q, beep_d;
   logic       over_q, over_d;
   logic       start_rise;

   // armed_q only sets once start has been seen low after reset, so a
   // button already held through reset release never counts as an edge.
   assign start_rise = start & ~start_d_q & armed_q;

   // Next-state and datapath decisions for the round sequencer.
   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      score_d      = score_q;
      time_d       = time_q;
      cnt_d        = cnt_q;
      guess_d      = guess_q;
      start_d_d    = start;
      armed_d      = armed_q | ~start;
      hit_d        = 1'b0;
      beep_d       = 1'b0;
      target_req_d = 1'b0;
      over_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_LOAD;
               round_d = 4'd0;
               score_d = 4'd0;
            end
         end
         S_LOAD: begin
            time_d  = TIME_INIT;
            state_d = S_PLAY;
         end
         S_PLAY: begin
            // A press beats a simultaneous tick: the clock freezes.
            if (start_rise) begin
               guess_d = sw;
               state_d = S_CHECK;
            end else if (tick) begin
               if (time_q > 4'd1) begin
                  time_d = time_q - 4'd1;
               end else begin
                  time_d  = 4'd0;
                  cnt_d   = 4'd0;
                  state_d = S_RESULT;
               end
            end
         end
         S_CHECK: begin
            cnt_d   = 4'd0;
            state_d = S_RESULT;
            if (guess_q == target) begin
               hit_d   = 1'b1;
               beep_d  = 1'b1;
               score_d = score_q + 4'd1;
            end
         end
         S_RESULT: begin
            // beep_q was decided on entry and holds for the whole dwell.
            beep_d = beep_q;
            if (tick) begin
               if (cnt_q + 4'd1 == BEEP_L) begin
                  cnt_d  = 4'd0;
                  beep_d = 1'b0;
                  if (round_q + 4'd1 == ROUNDS_L) begin
                     state_d = S_OVER;
                  end else begin
                     round_d = round_q + 4'd1;
                     state_d = S_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_OVER: begin
            if (start_rise) begin
               state_d = S_LOAD;
               round_d = 4'd0;
               score_d = 4'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered versions of state-decoded outputs line up with the state.
      target_req_d = (state_d == S_LOAD);
      over_d       = (state_d == S_OVER);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         round_q      <= 4'd0;
         score_q      <= 4'd0;
         time_q       <= 4'd0;
         cnt_q        <= 4'd0;
         guess_q      <= 7'd0;
         start_d_q    <= 1'b0;
         armed_q      <= 1'b0;
         target_req_q <= 1'b0;
         hit_q        <= 1'b0;
         beep_q       <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         score_q      <= score_d;
         time_q       <= time_d;
         cnt_q        <= cnt_d;
         guess_q      <= guess_d;
         start_d_q    <= start_d_d;
         armed_q      <= armed_d;
         target_req_q <= target_req_d;
         hit_q        <= hit_d;
         beep_q       <= beep_d;
         over_q       <= over_d;
      end
   end

   assign state      = state_q;
   assign round      = round_q;
   assign score      = score_q;
   assign time_left  = time_q;
   assign target_req = target_req_q;
   assign hit        = hit_q;
   assign beep_en    = beep_q;
   assign game_over  = over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed and randomized games against a game-level
// model (current round index and running score plus the round rules).
module tb_game_round_ctrl;

   localparam int ROUNDS     = 3;
   localparam int TIME_LIMIT = 9;
   localparam int BEEP_TICKS = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       start;
   logic [6:0] sw;
   logic [6:0] target;
   logic       target_req;
   logic [2:0] state;
   logic [3:0] round;
   logic [3:0] score;
   logic [3:0] time_left;
   logic       hit;
   logic       beep_en;
   logic       game_over;

   int n_checks = 0;
   int n_err    = 0;
   int m_round  = 0;
   int m_score  = 0;

   game_round_ctrl #(
      .ROUNDS(ROUNDS), .TIME_LIMIT(TIME_LIMIT), .BEEP_TICKS(BEEP_TICKS)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .sw(sw),
      .target(target), .target_req(target_req), .state(state),
      .round(round), .score(score), .time_left(time_left), .hit(hit),
      .beep_en(beep_en), .game_over(game_over)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fresh start press from IDLE or OVER: the game begins at round 0.
   task automatic press_new_game();
      start = 1'b1;
      step();
      start = 1'b0;
      m_round = 0;
      m_score = 0;
      chk("new_game_state", state, 1);
      chk("new_game_target_req", target_req, 1);
      chk("new_game_round", round, 0);
      chk("new_game_score", score, 0);
      chk("new_game_over_low", game_over, 0);
   endtask

   // One round, entered with LOAD observed. timeout=1 lets the clock run
   // out; otherwise n_ticks ticks elapse and then start is pressed with
   // guess on sw, optionally in the same cycle as a tick.
   task automatic run_round(input bit timeout, input logic [6:0] tgt,
                            input logic [6:0] guess, input int n_ticks,
                            input bit collide);
      int nt;
      int exp_hit;
      int exp_beep;
      target = tgt;
      step();
      chk("play_state", state, 2);
      chk("play_time_init", time_left, TIME_LIMIT);
      chk("play_target_req_low", target_req, 0);
      chk("play_round", round, m_round);
      nt = timeout ? TIME_LIMIT : n_ticks;
      for (int i = 1; i <= nt; i++) begin
         repeat ($urandom_range(0, 2)) begin
            step();
            chk("play_idle_time_hold", time_left, TIME_LIMIT - i + 1);
         end
         tick = 1'b1;
         step();
         tick = 1'b0;
         if (i == TIME_LIMIT) begin
            chk("timeout_state", state, 4);
            chk("timeout_time", time_left, 0);
         end else begin
            chk("tick_state", state, 2);
            chk("tick_time", time_left, TIME_LIMIT - i);
         end
      end
      if (timeout) begin
         exp_hit = 0;
         chk("timeout_hit", hit, 0);
         chk("timeout_score", score, m_score);
      end else begin
         sw    = guess;
         start = 1'b1;
         tick  = collide;
         step();
         start = 1'b0;
         tick  = 1'($urandom_range(0, 1));
         chk("check_state", state, 3);
         chk("check_time_frozen", time_left, TIME_LIMIT - n_ticks);
         chk("check_hit_low", hit, 0);
         step();
         tick = 1'b0;
         exp_hit = (guess == tgt) ? 1 : 0;
         chk("result_state", state, 4);
         chk("result_hit", hit, exp_hit);
         chk("result_score", score, m_score + exp_hit);
         m_score += exp_hit;
      end
      exp_beep = exp_hit;
      chk("result_beep", beep_en, exp_beep);
      step();
      chk("result_hit_pulse_end", hit, 0);
      chk("result_dwell_state", state, 4);
      // A start press inside RESULT is ignored.
      start = 1'b1;
      step();
      start = 1'b0;
      chk("result_start_ignored", state, 4);
      chk("result_beep_hold", beep_en, exp_beep);
      for (int b = 0; b < BEEP_TICKS; b++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         if (b < BEEP_TICKS - 1) chk("result_beep_mid", beep_en, exp_beep);
      end
      chk("exit_beep_low", beep_en, 0);
      if (m_round + 1 == ROUNDS) begin
         chk("over_state", state, 5);
         chk("over_flag", game_over, 1);
         chk("over_round", round, m_round);
         chk("over_score", score, m_score);
      end else begin
         m_round++;
         chk("next_load_state", state, 1);
         chk("next_target_req", target_req, 1);
         chk("next_round", round, m_round);
         chk("next_score", score, m_score);
      end
   endtask

   // Directed sequence followed by randomized games.
   initial begin
      bit         rand_to;
      logic [6:0] rt;
      logic [6:0] rg;
      rst    = 1'b0;
      start  = 1'b1;
      tick   = 1'b0;
      sw     = 7'd0;
      target = 7'd0;

      // Reset held with start high.
      repeat (10) begin
         tick = 1'($urandom_range(0, 1));
         step();
      end
      chk("rst_state", state, 0);
      chk("rst_round", round, 0);
      chk("rst_score", score, 0);
      chk("rst_time", time_left, 0);
      chk("rst_target_req", target_req, 0);
      chk("rst_hit", hit, 0);
      chk("rst_beep", beep_en, 0);
      chk("rst_game_over", game_over, 0);
      tick = 1'b0;
      rst  = 1'b1;
      repeat (3) step();
      chk("held_start_no_edge", state, 0);
      start = 1'b0;
      step();
      chk("idle_after_release", state, 0);

      // Full game of hits with target 0x2B.
      press_new_game();
      for (int r = 0; r < ROUNDS; r++)
         run_round(1'b0, 7'h2B, 7'h2B, $urandom_range(0, TIME_LIMIT - 1),
                   1'($urandom_range(0, 1)));
      chk("game1_final_score", score, ROUNDS);
      repeat (2) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
      chk("over_hold_state", state, 5);
      chk("over_hold_score", score, ROUNDS);
      chk("over_hold_round", round, ROUNDS - 1);
      chk("over_hold_beep", beep_en, 0);

      // Restart from OVER: timeout, wrong guess, collision at time_left 5.
      press_new_game();
      run_round(1'b1, 7'h2B, 7'h2B, 0, 1'b0);
      run_round(1'b0, 7'h2B, 7'h2A, 3, 1'b0);
      chk("wrong_guess_score", score, 0);
      run_round(1'b0, 7'h11, 7'h11, 4, 1'b1);
      chk("game2_final_score", score, 1);

      // Randomized game.
      press_new_game();
      for (int r = 0; r < ROUNDS; r++) begin
         rand_to = ($urandom_range(0, 3) == 0);
         rt = 7'($urandom_range(0, 127));
         rg = ($urandom_range(0, 1) == 1) ? rt : (rt ^ 7'($urandom_range(1, 127)));
         run_round(rand_to, rt, rg, $urandom_range(0, TIME_LIMIT - 1),
                   1'($urandom_range(0, 1)));
      end

      // Mid-game reset during round 1 PLAY.
      press_new_game();
      run_round(1'b0, 7'h05, 7'h05, 1, 1'b0);
      step();
      chk("mid_round1_play", state, 2);
      tick = 1'b1;
      step();
      tick = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_score", score, 0);
      chk("async_rst_round", round, 0);
      chk("async_rst_time", time_left, 0);
      step();
      rst = 1'b1;
      step();
      chk("post_rst_idle", state, 0);
      press_new_game();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
